multi_edge_detect: RTL and testbench

//  Parametrised N-channel edge detector for the USB receive front end.

---
 rtl/multi_edge_detect_pkg.sv | 33 +++
 rtl/multi_edge_detect_edge_chan.sv | 133 +++++++++++++
 rtl/multi_edge_detect.sv | 69 ++++++
 tb/tb_multi_edge_detect.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/multi_edge_detect_pkg.sv
// -----------------------------------------------------------------------------
// usb_edge_pkg
//
// Shared types and helpers for the multi-channel edge detector used in the USB
// receive front end.
//
// Contents:
//   edge_mode_t  - per-channel edge qualification mode (off / rise / fall / both)
//   filt_width() - width of the glitch-filter counter for a given filter length
// -----------------------------------------------------------------------------
package usb_edge_pkg;

    // Encoding is part of the external interface: each channel takes two bits
    // of the flat edge_mode bus.
    typedef enum logic [1:0] {
        EDGE_OFF  = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2,
        EDGE_BOTH = 2'd3
    } edge_mode_t;

    // Counter must hold 0..n inclusive.
    // n = 0 still needs a 1-bit counter so the port/signal widths stay legal.
    function automatic int filt_width(input int n);
        int w;
        w = $clog2(n + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multi_edge_detect_edge_chan.sv
// -----------------------------------------------------------------------------
// edge_chan
//
// One channel of the edge detector:
//   asynchronous line -> synchroniser chain -> glitch filter -> edge qualify
//   -> one-cycle pulse + sticky flag.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth (must be >= 2)
//   FILT_CYCLES  extra cycles the synced level must differ from the filtered
//                level before it is accepted (0 disables the filter)
//   RST_LVL      idle/reset level of this line
//
// Ports:
//   clk          system clock, all state on the rising edge
//   n_rst        asynchronous active-low reset
//   din          raw asynchronous line input
//   edge_mode    which edge types produce a pulse
//   clear        one-cycle strobe that clears the sticky flag
//   d_filt       synchronised, filtered line level
//   edge_pulse   one-cycle pulse for each qualifying accepted edge
//   edge_sticky  latched edge flag, held until clear
// -----------------------------------------------------------------------------
module edge_chan
    import usb_edge_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 2,
    parameter logic RST_LVL     = 1'b0
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       din,
    input  edge_mode_t edge_mode,
    input  logic       clear,
    output logic       d_filt,
    output logic       edge_pulse,
    output logic       edge_sticky
);

    localparam int            CW       = filt_width(FILT_CYCLES);
    localparam logic [CW-1:0] FILT_MAX = CW'(FILT_CYCLES);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;

    logic                   d_filt_reg;
    logic                   d_filt_next;
    logic [CW-1:0]          cnt_reg;
    logic [CW-1:0]          cnt_next;
    logic                   accept;
    logic                   mode_match;

    logic                   pulse_reg;
    logic                   pulse_next;
    logic                   sticky_reg;
    logic                   sticky_next;

    // -------------------------------------------------------------------------
    // Synchroniser. Resets to the idle level so that releasing reset with the
    // line idle never looks like an edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_reg <= {SYNC_STAGES{RST_LVL}};
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Glitch filter. The synced level has to disagree with the filtered level
    // on FILT_CYCLES+1 consecutive edges; the last of those is the accept edge.
    // Any agreement in between restarts the count, so short pulses vanish.
    // The counter saturates at FILT_MAX and never wraps.
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next    = '0;
        d_filt_next = d_filt_reg;
        accept      = 1'b0;
        if (s != d_filt_reg) begin
            if (cnt_reg == FILT_MAX) begin
                accept      = 1'b1;
                d_filt_next = s;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge qualification. On an accept edge the new level equals s, so s=1
    // means a rising edge and s=0 a falling one. The mode is sampled only at
    // the accept edge, so changing it mid-count affects that pending edge.
    // -------------------------------------------------------------------------
    always_comb begin
        mode_match = 1'b0;
        case (edge_mode)
            EDGE_RISE: mode_match = s;
            EDGE_FALL: mode_match = ~s;
            EDGE_BOTH: mode_match = 1'b1;
            default:   mode_match = 1'b0;
        endcase
    end

    assign pulse_next = accept & mode_match;

    // The sticky flag is set from the registered pulse, so it rises one cycle
    // after edge_pulse. A clear strobed during the pulse cycle therefore lands
    // on the same edge as the set, and the set wins so no event is lost.
    assign sticky_next = pulse_reg | (sticky_reg & ~clear);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_filt_reg <= RST_LVL;
            cnt_reg    <= '0;
            pulse_reg  <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            d_filt_reg <= d_filt_next;
            cnt_reg    <= cnt_next;
            pulse_reg  <= pulse_next;
            sticky_reg <= sticky_next;
        end
    end

    assign d_filt      = d_filt_reg;
    assign edge_pulse  = pulse_reg;
    assign edge_sticky = sticky_reg;

endmodule

// File: rtl/multi_edge_detect.sv
// -----------------------------------------------------------------------------
// multi_edge_detect
//
// N-channel edge detector for the USB receive front end (d_plus / d_minus).
// Each channel is an independent edge_chan; this level only slices the flat
// buses and forms d_edge, the OR of all channel pulses, which feeds the
// bit-timing / decoder logic.
//
// Parameters:
//   NUM_CH       number of input channels
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   FILT_CYCLES  glitch filter length in extra cycles (0 = no filter)
//   RST_VAL      per-channel idle/reset level (bit0 d_plus=1, bit1 d_minus=0)
//
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   din          raw asynchronous line inputs
//   edge_mode    per-channel edge_mode_t, channel i at [2i+1:2i]
//   clear        per-channel sticky clear strobe
//   d_filt       synchronised, filtered line levels
//   edge_pulse   per-channel one-cycle qualifying edge pulse
//   edge_sticky  per-channel latched edge flag
//   d_edge       OR of edge_pulse
// -----------------------------------------------------------------------------
module multi_edge_detect
    import usb_edge_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CYCLES = 2,
    parameter logic [NUM_CH-1:0] RST_VAL     = 2'b01
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [NUM_CH-1:0]     din,
    input  logic [2*NUM_CH-1:0]   edge_mode,
    input  logic [NUM_CH-1:0]     clear,
    output logic [NUM_CH-1:0]     d_filt,
    output logic [NUM_CH-1:0]     edge_pulse,
    output logic [NUM_CH-1:0]     edge_sticky,
    output logic                  d_edge
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
            edge_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILT_CYCLES (FILT_CYCLES),
                .RST_LVL     (RST_VAL[gi])
            ) u_chan (
                .clk         (clk),
                .n_rst       (n_rst),
                .din         (din[gi]),
                .edge_mode   (edge_mode_t'(edge_mode[2*gi+1 -: 2])),
                .clear       (clear[gi]),
                .d_filt      (d_filt[gi]),
                .edge_pulse  (edge_pulse[gi]),
                .edge_sticky (edge_sticky[gi])
            );
        end
    endgenerate

    // Pulses are registered, so d_edge is glitch-free; coincident edges on
    // several channels merge into a single d_edge cycle.
    assign d_edge = |edge_pulse;

endmodule

// File: tb/tb_multi_edge_detect.sv
`timescale 1ns/1ps
module tb_multi_edge_detect;
    import usb_edge_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [1:0] din;
    logic [3:0] edge_mode;
    logic [1:0] clear;
    logic [1:0] d_filt;
    logic [1:0] edge_pulse;
    logic [1:0] edge_sticky;
    logic       d_edge;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] din;
        logic [3:0] mode;
        logic [1:0] clr;
        logic [1:0] df;
        logic [1:0] ep;
        logic [1:0] es;
    } vec_t;

    vec_t vecs[$];

    always #5.25 clk = ~clk;

    multi_edge_detect #(
        .NUM_CH      (2),
        .SYNC_STAGES (2),
        .FILT_CYCLES (2),
        .RST_VAL     (2'b01)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .din         (din),
        .edge_mode   (edge_mode),
        .clear       (clear),
        .d_filt      (d_filt),
        .edge_pulse  (edge_pulse),
        .edge_sticky (edge_sticky),
        .d_edge      (d_edge)
    );

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Check all outputs against one expected set.
    task automatic chk_all(input string name, input logic [1:0] df,
                           input logic [1:0] ep, input logic [1:0] es);
        logic [1:0] de;
        de = {1'b0, |ep};
        chk({name, " d_filt"}, d_filt, df);
        chk({name, " edge_pulse"}, edge_pulse, ep);
        chk({name, " edge_sticky"}, edge_sticky, es);
        chk({name, " d_edge"}, {1'b0, d_edge}, de);
        $display("%s: din=%b mode=%b clr=%b -> d_filt=%b pulse=%b sticky=%b d_edge=%b",
                 name, din, edge_mode, clear, d_filt, edge_pulse, edge_sticky, d_edge);
    endtask

    task automatic add(input string tag, input logic [1:0] d, input logic [3:0] m,
                       input logic [1:0] c, input logic [1:0] df, input logic [1:0] ep,
                       input logic [1:0] es, input int n);
        vec_t v;
        v.tag = tag; v.din = d; v.mode = m; v.clr = c;
        v.df = df; v.ep = ep; v.es = es;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        // ------------------------------------------------------------------
        // Vector table: one record per clock; expected values are the
        // outputs after the rising edge that samples that record's inputs.
        // ------------------------------------------------------------------
        // ch0 fall, BOTH: pulse on the 5th edge, sticky the cycle after
        add("t2_fall",      2'b00, 4'b1111, 2'b00, 2'b01, 2'b00, 2'b00, 4);
        add("t2_fall_acc",  2'b00, 4'b1111, 2'b00, 2'b00, 2'b01, 2'b00, 1);
        add("t2_fall_post", 2'b00, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 2);
        // ch1 2-cycle glitch: rejected
        add("t3_glitch_hi", 2'b10, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 2);
        add("t3_glitch_lo", 2'b00, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 6);
        // ch1 3-cycle pulse: accepted, then its trailing fall also accepted
        add("t3_pulse_hi",  2'b10, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 3);
        add("t3_pulse_lo",  2'b00, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b01, 1);
        add("t3_pulse_acc", 2'b00, 4'b1111, 2'b00, 2'b10, 2'b10, 2'b01, 1);
        add("t3_pulse_hold",2'b00, 4'b1111, 2'b00, 2'b10, 2'b00, 2'b11, 2);
        add("t3_fall_acc",  2'b00, 4'b1111, 2'b00, 2'b00, 2'b10, 2'b11, 1);
        add("t3_fall_post", 2'b00, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b11, 1);
        // clear both stickies, ch0 RISE mode
        add("t4_clear",     2'b00, 4'b1101, 2'b11, 2'b00, 2'b00, 2'b00, 1);
        add("t4_rise",      2'b01, 4'b1101, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        add("t4_rise_acc",  2'b01, 4'b1101, 2'b00, 2'b01, 2'b01, 2'b00, 1);
        // clear in the pulse cycle: set wins; clear alone next cycle: cleared
        add("t5_clr_set",   2'b01, 4'b1101, 2'b01, 2'b01, 2'b00, 2'b01, 1);
        add("t5_clr",       2'b01, 4'b1101, 2'b01, 2'b01, 2'b00, 2'b00, 1);
        add("t5_idle",      2'b01, 4'b1101, 2'b00, 2'b01, 2'b00, 2'b00, 1);
        // ch0 fall under RISE: level follows, no pulse
        add("t4_fall_rm",   2'b00, 4'b1101, 2'b00, 2'b01, 2'b00, 2'b00, 4);
        add("t4_fall_rm_a", 2'b00, 4'b1101, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        // OFF on both channels: both edge types, no pulse, no sticky
        add("t4_off_rise",  2'b11, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        add("t4_off_r_acc", 2'b11, 4'b0000, 2'b00, 2'b11, 2'b00, 2'b00, 3);
        add("t4_off_fall",  2'b00, 4'b0000, 2'b00, 2'b11, 2'b00, 2'b00, 4);
        add("t4_off_f_acc", 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        // mode switched OFF->BOTH mid-count: pending edge still pulses
        add("t4_pend_off",  2'b01, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        add("t4_pend_both", 2'b01, 4'b1111, 2'b00, 2'b00, 2'b00, 2'b00, 2);
        add("t4_pend_acc",  2'b01, 4'b1111, 2'b00, 2'b01, 2'b01, 2'b00, 1);
        add("t4_pend_post", 2'b01, 4'b1111, 2'b00, 2'b01, 2'b00, 2'b01, 1);
        // both channels change together: one d_edge cycle
        add("t6_clear",     2'b01, 4'b1111, 2'b11, 2'b01, 2'b00, 2'b00, 1);
        add("t6_both",      2'b10, 4'b1111, 2'b00, 2'b01, 2'b00, 2'b00, 4);
        add("t6_both_acc",  2'b10, 4'b1111, 2'b00, 2'b10, 2'b11, 2'b00, 1);
        add("t6_both_post", 2'b10, 4'b1111, 2'b00, 2'b10, 2'b00, 2'b11, 2);

        // ------------------------------------------------------------------
        // Test 1: reset behaviour
        // ------------------------------------------------------------------
        n_rst = 1'b1; din = 2'b01; edge_mode = 4'b1111; clear = 2'b00;
        #1 n_rst = 1'b0;
        #1 chk_all("t1_reset_initial", 2'b01, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            din = (k % 2 == 0) ? 2'b10 : 2'b01;
            chk_all($sformatf("t1_reset_toggle[%0d]", k), 2'b01, 2'b00, 2'b00);
        end
        din = 2'b01;
        @(negedge clk);
        #2 n_rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_all($sformatf("t1_release[%0d]", k), 2'b01, 2'b00, 2'b00);
        end
        // drive both channels away from idle, then reset mid-cycle
        din = 2'b10;
        repeat (7) @(negedge clk);
        chk_all("t1_pre_reset", 2'b10, 2'b00, 2'b11);
        #3 n_rst = 1'b0;
        #1 chk_all("t1_reset_immediate", 2'b01, 2'b00, 2'b00);
        din = 2'b01;
        @(negedge clk);
        #2 n_rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_all($sformatf("t1_release2[%0d]", k), 2'b01, 2'b00, 2'b00);
        end

        // ------------------------------------------------------------------
        // Table-driven vectors
        // ------------------------------------------------------------------
        foreach (vecs[i]) begin
            din       = vecs[i].din;
            edge_mode = vecs[i].mode;
            clear     = vecs[i].clr;
            @(negedge clk);
            chk_all($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].df, vecs[i].ep, vecs[i].es);
        end
        clear = 2'b00;

        // ------------------------------------------------------------------
        // Test 6b: reset while the filter counter is part-way through
        // ------------------------------------------------------------------
        din = 2'b11;
        repeat (3) @(negedge clk);
        chk_all("t6_midcount", 2'b10, 2'b00, 2'b11);
        #2 n_rst = 1'b0;
        #1 chk_all("t6_mid_reset", 2'b01, 2'b00, 2'b00);
        din = 2'b01;
        @(negedge clk);
        #2 n_rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk_all($sformatf("t6_mid_release[%0d]", k), 2'b01, 2'b00, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
